// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver with a synchronized rx line.
// Frame is 8N1 by default. Define UART_RX_PARITY_EN to add a parity bit
// after the data bits (captured and checked for even parity).
module uart_rx_sampler #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [31:0] byte_rate,
  input  logic        rx_flag_clr,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_flag,
  output logic        parity,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam logic [CNT_W-1:0] MIN_RATE = CNT_W'(4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BRK
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                r_rx_prev;
  logic                w_rx, w_fall, w_bit_mid, w_bit_end;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]    r_bit_len, w_bit_len_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic [IDX_W-1:0]    r_bit_idx, w_bit_idx_nxt;
  logic                r_fin, w_fin_nxt;
  logic                r_stop_bit, w_stop_nxt;
`ifdef UART_RX_PARITY_EN
  logic                r_par_bit, w_par_nxt;
`endif

  // rx synchronizer; r_rx_prev resets low so a start edge needs a high sample after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
      r_rx_prev <= w_rx;
    end
  end

  assign w_rx      = r_sync[SYNC_STAGES-1];
  assign w_fall    = r_rx_prev & ~w_rx;
  assign w_bit_mid = (r_cnt == (r_bit_len >> 1));
  assign w_bit_end = (r_cnt == (r_bit_len - CNT_W'(1)));

  // state and frame datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_len  <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_fin      <= 1'b0;
      r_stop_bit <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_len  <= w_bit_len_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_fin      <= w_fin_nxt;
      r_stop_bit <= w_stop_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= w_par_nxt;
`endif
    end
  end

  // next-state, bit timing and sampling
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_len_nxt = r_bit_len;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_fin_nxt     = 1'b0;
    w_stop_nxt    = r_stop_bit;
`ifdef UART_RX_PARITY_EN
    w_par_nxt     = r_par_bit;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_fall && (byte_rate >= MIN_RATE)) begin
          w_bit_len_nxt = byte_rate;
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_mid) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt   = {w_rx, r_shift[DATA_W-1:1]};
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
          if (r_bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PAR;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_PAR: begin
`ifdef UART_RX_PARITY_EN
        if (w_bit_end) begin
          w_par_nxt   = w_rx;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`else
        w_state_nxt = ST_STOP;
`endif
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_fin_nxt   = 1'b1;
          w_stop_nxt  = w_rx;
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx ? ST_IDLE : ST_BRK;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_BRK: begin
        if (w_rx) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // frame results, sticky flag and overrun, one clock after the stop sample
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_flag    <= 1'b0;
      parity     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_valid <= r_fin;
      if (r_fin) begin
        rx_data   <= r_shift;
        frame_err <= ~r_stop_bit;
`ifdef UART_RX_PARITY_EN
        parity     <= r_par_bit;
        parity_err <= ^{r_shift, r_par_bit};
`else
        parity     <= 1'b0;
        parity_err <= 1'b0;
`endif
      end
      if (r_fin)            rx_flag <= 1'b1;
      else if (rx_flag_clr) rx_flag <= 1'b0;
      if (rx_flag_clr)             overrun <= 1'b0;
      else if (r_fin && rx_flag)   overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: directed frames plus randomized traffic.
module tb_uart_rx_sampler;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [31:0] byte_rate;
  logic        rx_flag_clr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_flag;
  logic        parity;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;

  uart_rx_sampler #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .byte_rate(byte_rate),
    .rx_flag_clr(rx_flag_clr), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_flag(rx_flag), .parity(parity), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  // reference state: what the receiver outputs should read when idle
  logic [7:0] m_data;
  logic       m_par, m_perr, m_ferr, m_flag, m_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":rx_data"},    32'(rx_data),    32'(m_data));
    chk({tag, ":rx_flag"},    32'(rx_flag),    32'(m_flag));
    chk({tag, ":overrun"},    32'(overrun),    32'(m_ovr));
    chk({tag, ":frame_err"},  32'(frame_err),  32'(m_ferr));
    chk({tag, ":parity_err"}, 32'(parity_err), 32'(m_perr));
    chk({tag, ":parity"},     32'(parity),     32'(m_par));
    chk({tag, ":rx_valid"},   32'(rx_valid),   32'(1'b0));
  endtask

  task automatic model_reset();
    m_data = '0; m_par = 0; m_perr = 0; m_ferr = 0; m_flag = 0; m_ovr = 0;
  endtask

  // drive one frame at `rate` clocks per bit; scrambles byte_rate mid-frame
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input int unsigned rate, input int unsigned brk_hold);
    exp_t e;
    e.data = d;
    e.par  = PAR_EN ? pbit : 1'b0;
    e.perr = PAR_EN ? ((^d) ^ pbit) : 1'b0;
    e.ferr = ~stop;
    e.ovr  = m_ovr | m_flag;
    q.push_back(e);
    m_data = e.data; m_par = e.par; m_perr = e.perr; m_ferr = e.ferr;
    m_ovr  = e.ovr;  m_flag = 1'b1;

    byte_rate = rate;
    @(negedge clk);
    rx = 1'b0;
    repeat (rate) @(negedge clk);
    byte_rate = $urandom;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (rate) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = pbit;
      repeat (rate) @(negedge clk);
    end
    rx = stop;
    repeat (rate) @(negedge clk);
    if (!stop) repeat (brk_hold) @(negedge clk);
    rx = 1'b1;
    repeat (4 + $urandom_range(0, rate)) @(negedge clk);
  endtask

  task automatic clr_pulse();
    rx_flag_clr = 1'b1;
    @(negedge clk);
    rx_flag_clr = 1'b0;
    m_flag = 1'b0;
    m_ovr  = 1'b0;
    @(negedge clk);
    check_state("after_clr");
  endtask

  // monitor: pop one expectation per rx_valid pulse
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid) begin
      chk("rx_valid_width", 32'(prev_valid), 32'(1'b0));
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rx_valid actual=1 expected=0 data=%0h at %0t", rx_data, $time);
      end else begin
        e = q.pop_front();
        chk("mon:rx_data",    32'(rx_data),    32'(e.data));
        chk("mon:parity",     32'(parity),     32'(e.par));
        chk("mon:parity_err", 32'(parity_err), 32'(e.perr));
        chk("mon:frame_err",  32'(frame_err),  32'(e.ferr));
        chk("mon:rx_flag",    32'(rx_flag),    32'(1'b1));
        chk("mon:overrun",    32'(overrun),    32'(e.ovr));
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    logic [7:0]  d;
    logic        pb, st;
    int unsigned rate;

    clk = 1'b0; rst = 1'b0; rx = 1'b1; byte_rate = 32'd16; rx_flag_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // basic frame, then parity-error frame
    send_frame(8'hA5, 1'b0, 1'b1, 16, 0);
    check_state("frame_a5");
    clr_pulse();
    send_frame(8'h3C, 1'b1, 1'b1, 16, 0);
    check_state("frame_3c");
    clr_pulse();

    // 5-clock glitch must be rejected
    byte_rate = 32'd16;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check_state("glitch");

    // overrun on back-to-back frames, cleared by rx_flag_clr
    send_frame(8'h11, 1'b0, 1'b1, 16, 0);
    send_frame(8'h22, 1'b0, 1'b1, 16, 0);
    check_state("overrun");
    clr_pulse();

    // break: stop low, line held low
    send_frame(8'h55, 1'b0, 1'b0, 16, 40);
    check_state("break");
    clr_pulse();

    // reset during data bit 4 abandons the frame
    byte_rate = 32'd16;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    d = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = d[4];
    repeat (8) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_state("mid_reset");
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check_state("post_reset");
    send_frame(8'h81, 1'b0, 1'b1, 16, 0);
    check_state("frame_81");

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      pb   = 1'($urandom);
      st   = ($urandom_range(0, 9) != 0);
      rate = $urandom_range(8, 24);
      send_frame(d, pb, st, rate, $urandom_range(0, 30));
      if ($urandom_range(0, 2) == 0) clr_pulse();
    end
    check_state("random_end");

    repeat (50) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
